// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register pending-write scoreboard; optional SCOREBOARD_WB_BYPASS_EN
module reg_scoreboard #(
    parameter int MAX_PENDING = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        issue_valid,
    input  logic [4:0]  issue_dest,
    output logic        issue_ready,
    input  logic        wb_valid,
    input  logic [4:0]  wb_dest,
    input  logic [4:0]  query_rs,
    input  logic [4:0]  query_rt,
    output logic        hazard_rs,
    output logic        hazard_rt,
    output logic [31:0] busy_vector,
    output logic        wb_error
);

    localparam logic [1:0] MAX_CNT = 2'(MAX_PENDING);

    logic [1:0] count_q [1:31];
    logic [1:0] issue_count;
    logic [1:0] wb_count;
    logic [1:0] rs_count;
    logic [1:0] rt_count;
    logic       issue_accept;
    logic       wb_live;
    logic       wb_orphan;

    // Register 0 has no counter, so every lookup defaults to zero for it.
    always_comb begin
        issue_count = 2'd0;
        wb_count    = 2'd0;
        rs_count    = 2'd0;
        rt_count    = 2'd0;
        busy_vector = 32'd0;
        for (int i = 1; i < 32; i++) begin
            if (issue_dest == 5'(i)) issue_count = count_q[i];
            if (wb_dest == 5'(i))    wb_count    = count_q[i];
            if (query_rs == 5'(i))   rs_count    = count_q[i];
            if (query_rt == 5'(i))   rt_count    = count_q[i];
            busy_vector[i] = (count_q[i] != 2'd0);
        end
    end

    assign issue_ready  = (issue_dest == 5'd0) || (issue_count < MAX_CNT);
    assign issue_accept = issue_valid && issue_ready;
    assign wb_live      = wb_valid && (wb_dest != 5'd0);
    assign wb_orphan    = wb_live && (wb_count == 2'd0);

`ifdef SCOREBOARD_WB_BYPASS_EN
    // A write-back retiring the last pending write releases the hazard immediately.
    assign hazard_rs = busy_vector[query_rs] &&
                       !(wb_valid && (wb_dest == query_rs) && (rs_count == 2'd1));
    assign hazard_rt = busy_vector[query_rt] &&
                       !(wb_valid && (wb_dest == query_rt) && (rt_count == 2'd1));
`else
    logic unused_counts;
    assign unused_counts = ^{rs_count, rt_count};
    assign hazard_rs = busy_vector[query_rs];
    assign hazard_rt = busy_vector[query_rt];
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 1; i < 32; i++) count_q[i] <= 2'd0;
            wb_error <= 1'b0;
        end else begin
            if (wb_orphan) wb_error <= 1'b1;
            if (flush) begin
                for (int i = 1; i < 32; i++) count_q[i] <= 2'd0;
            end else begin
                for (int i = 1; i < 32; i++) begin
                    logic inc;
                    logic dec;
                    inc = issue_accept && (issue_dest == 5'(i));
                    dec = wb_live && (wb_dest == 5'(i)) && (count_q[i] != 2'd0);
                    if (inc && !dec)      count_q[i] <= count_q[i] + 2'd1;
                    else if (dec && !inc) count_q[i] <= count_q[i] - 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - randomized and directed self-checking bench for reg_scoreboard
module tb_reg_scoreboard;

    localparam int MAXP = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        issue_valid;
    logic [4:0]  issue_dest;
    logic        issue_ready;
    logic        wb_valid;
    logic [4:0]  wb_dest;
    logic [4:0]  query_rs;
    logic [4:0]  query_rt;
    logic        hazard_rs;
    logic        hazard_rt;
    logic [31:0] busy_vector;
    logic        wb_error;

    int checks   = 0;
    int failures = 0;

    int model_cnt [32];
    bit model_err;

    reg_scoreboard #(.MAX_PENDING(MAXP)) dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .issue_valid (issue_valid),
        .issue_dest  (issue_dest),
        .issue_ready (issue_ready),
        .wb_valid    (wb_valid),
        .wb_dest     (wb_dest),
        .query_rs    (query_rs),
        .query_rt    (query_rt),
        .hazard_rs   (hazard_rs),
        .hazard_rt   (hazard_rt),
        .busy_vector (busy_vector),
        .wb_error    (wb_error)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit model_hazard(input int q);
        bit h;
        h = (q != 0) && (model_cnt[q] != 0);
`ifdef SCOREBOARD_WB_BYPASS_EN
        if (wb_valid && int'(wb_dest) == q && model_cnt[q] == 1) h = 0;
`endif
        return h;
    endfunction

    task automatic drive(input bit iv, input int id, input bit wv, input int wd,
                         input int qs, input int qt, input bit fl);
        issue_valid = iv;
        issue_dest  = 5'(id);
        wb_valid    = wv;
        wb_dest     = 5'(wd);
        query_rs    = 5'(qs);
        query_rt    = 5'(qt);
        flush       = fl;
    endtask

    // Compare every output against the model mid-cycle, then advance the model at the edge.
    task automatic cycle();
        bit          exp_ready;
        bit          accept;
        logic [31:0] exp_busy;
        int          id;
        int          wd;
        int          old_w;
        @(negedge clock);
        id = int'(issue_dest);
        wd = int'(wb_dest);
        exp_ready = (id == 0) || (model_cnt[id] < MAXP);
        exp_busy  = '0;
        for (int n = 1; n < 32; n++) exp_busy[n] = (model_cnt[n] != 0);
        check("issue_ready", {31'd0, issue_ready}, {31'd0, exp_ready});
        check("busy_vector", busy_vector, exp_busy);
        check("hazard_rs", {31'd0, hazard_rs}, {31'd0, model_hazard(int'(query_rs))});
        check("hazard_rt", {31'd0, hazard_rt}, {31'd0, model_hazard(int'(query_rt))});
        check("wb_error", {31'd0, wb_error}, {31'd0, model_err});
        accept = issue_valid && exp_ready;
        @(posedge clock);
        if (!reset) begin
            for (int n = 0; n < 32; n++) model_cnt[n] = 0;
            model_err = 0;
        end else begin
            old_w = model_cnt[wd];
            if (wb_valid && wd != 0 && old_w == 0) model_err = 1;
            if (flush) begin
                for (int n = 0; n < 32; n++) model_cnt[n] = 0;
            end else begin
                if (accept && id != 0) model_cnt[id] = model_cnt[id] + 1;
                if (wb_valid && wd != 0 && old_w > 0) model_cnt[wd] = model_cnt[wd] - 1;
            end
        end
        #1;
    endtask

    initial begin
        for (int n = 0; n < 32; n++) model_cnt[n] = 0;
        model_err = 0;
        reset = 1'b0;
        drive(1, 5, 1, 9, 5, 9, 0);
        @(posedge clock);
        #1;
        for (int n = 0; n < 32; n++) model_cnt[n] = 0;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        check("rst_busy", busy_vector, 32'h0);
        check("rst_ready", {31'd0, issue_ready}, 32'd1);
        check("rst_err", {31'd0, wb_error}, 32'd0);

        // Fill register 5 to the limit, then retire one write.
        repeat (3) begin drive(1, 5, 0, 0, 5, 0, 0); cycle(); end
        drive(1, 5, 0, 0, 5, 0, 0);
        #1;
        check("full_busy", busy_vector, 32'h20);
        check("full_ready", {31'd0, issue_ready}, 32'd0);
        cycle();
        drive(0, 5, 1, 5, 0, 0, 0); cycle();
        drive(1, 5, 0, 0, 0, 0, 0);
        #1;
        check("after_wb_ready", {31'd0, issue_ready}, 32'd1);
        drive(0, 0, 1, 5, 0, 0, 0); cycle();
        drive(0, 0, 1, 5, 0, 0, 0); cycle();

        // Issue and write-back to the same register hold the count.
        drive(1, 7, 0, 0, 7, 0, 0); cycle();
        drive(1, 7, 1, 7, 7, 0, 0); cycle();
        drive(0, 0, 0, 0, 7, 0, 0);
        #1;
        check("same_reg_hazard", {31'd0, hazard_rs}, 32'd1);
        check("same_reg_busy", busy_vector, 32'h80);
        cycle();
        drive(0, 0, 1, 7, 0, 0, 0); cycle();

        // Orphan write-back is sticky across flush; register 0 write-back is ignored.
        drive(0, 0, 1, 9, 0, 0, 0); cycle();
        drive(0, 0, 0, 0, 0, 0, 1); cycle();
        #1;
        check("err_sticky", {31'd0, wb_error}, 32'd1);
        reset = 1'b0; drive(0, 0, 0, 0, 0, 0, 0); cycle();
        reset = 1'b1;
        drive(0, 0, 1, 0, 0, 0, 0); cycle();
        #1;
        check("wb0_no_err", {31'd0, wb_error}, 32'd0);

        // Bypass behaviour on the last pending write.
        drive(1, 3, 0, 0, 0, 3, 0); cycle();
        drive(0, 0, 1, 3, 0, 3, 0);
        #1;
`ifdef SCOREBOARD_WB_BYPASS_EN
        check("bypass_same", {31'd0, hazard_rt}, 32'd0);
`else
        check("bypass_same", {31'd0, hazard_rt}, 32'd1);
`endif
        cycle();
        drive(0, 0, 0, 0, 0, 3, 0);
        #1;
        check("bypass_next", {31'd0, hazard_rt}, 32'd0);

        // Flush beats a simultaneous issue.
        drive(1, 6, 0, 0, 0, 0, 0); cycle();
        drive(1, 4, 0, 0, 0, 0, 1); cycle();
        #1;
        check("flush_busy", busy_vector, 32'h0);

        // Random traffic over a narrow register window to force collisions.
        for (int k = 0; k < 4000; k++) begin
            reset = ($urandom % 400) != 0;
            drive(($urandom % 3) != 0, $urandom % 8, ($urandom % 2) != 0, $urandom % 8,
                  $urandom % 8, $urandom % 8, ($urandom % 50) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
